// File: rtl/clz_seq.sv
// clz_seq: sequential 32-bit count-leading-zeros, scanning one 4-bit nibble per clock, MSB nibble first.
// Optional macro CLZ_EARLY_EXIT_EN ends the scan at the first nonzero nibble; otherwise latency is always 8 scan edges.
//
// state | meaning
// IDLE  | waiting for start; count/isZero hold the last result
// SCAN  | one nibble examined per edge; busy high
module clz_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] a,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic        isZero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_shift;
  logic [5:0]  r_acc;
  logic [2:0]  r_idx;
  logic        r_found;
  logic [5:0]  r_count;
  logic        r_iszero;
  logic        r_done;

  logic [3:0]  w_nib;
  logic        w_nib_nz;
  logic [2:0]  w_nib_lz;
  logic [5:0]  w_acc_step;
  logic        w_found_nxt;
  logic        w_last;
  logic        w_accept;
  logic        w_scan;

  assign w_nib    = r_shift[31:28];
  assign w_nib_nz = (w_nib != 4'd0);
  assign w_accept = (r_state == IDLE) && start;
  assign w_scan   = (r_state == SCAN);

  // A zero nibble contributes 4, so the encoder's default covers that case.
  always_comb begin
    w_nib_lz = 3'd4;
    casez (w_nib)
      4'b1???: w_nib_lz = 3'd0;
      4'b01??: w_nib_lz = 3'd1;
      4'b001?: w_nib_lz = 3'd2;
      4'b0001: w_nib_lz = 3'd3;
      default: w_nib_lz = 3'd4;
    endcase
  end

  assign w_acc_step  = r_found ? r_acc : (r_acc + {3'b000, w_nib_lz});
  assign w_found_nxt = r_found | w_nib_nz;

`ifdef CLZ_EARLY_EXIT_EN
  assign w_last = (r_idx == 3'd7) || w_nib_nz;
`else
  assign w_last = (r_idx == 3'd7);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = SCAN;
      SCAN:    if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift  <= 32'd0;
      r_acc    <= 6'd0;
      r_idx    <= 3'd0;
      r_found  <= 1'b0;
      r_count  <= 6'd0;
      r_iszero <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_scan && w_last;
      if (w_accept) begin
        r_shift <= a;
        r_acc   <= 6'd0;
        r_idx   <= 3'd0;
        r_found <= 1'b0;
      end else if (w_scan) begin
        r_acc   <= w_acc_step;
        r_found <= w_found_nxt;
        r_idx   <= r_idx + 3'd1;
        // Only zero nibbles are shifted out; a found nibble stays parked at the top.
        if (!w_nib_nz) begin
          r_shift <= {r_shift[27:0], 4'd0};
        end
        if (w_last) begin
          r_count  <= w_acc_step;
          r_iszero <= (w_acc_step == 6'd32);
        end
      end
    end
  end

  assign busy   = w_scan;
  assign done   = r_done;
  assign count  = r_count;
  assign isZero = r_iszero;

`ifndef SYNTHESIS
  a_acc_range: assert property (@(posedge clock) disable iff (!reset_n) r_acc <= 6'd32);
  a_done_pulse: assert property (@(posedge clock) disable iff (!reset_n) done |=> !done);
  a_done_idle: assert property (@(posedge clock) disable iff (!reset_n) done |-> !busy);
`endif

endmodule

// File: doc/clz_seq.md
CLZ_SEQ -- requirements
Module: clz_seq

Interface
REQ-001 SHALL have no parameters: operand width fixed at 32 bits, scanned as eight 4-bit nibble groups.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a count, sampled only in IDLE.
REQ-005 SHALL have port a, input, 32, operand, sampled on the edge that accepts start.
REQ-006 SHALL have port busy, output, 1, high while in SCAN.
REQ-007 SHALL have port done, output, 1, one-cycle pulse marking count and isZero as newly valid.
REQ-008 SHALL have port count, output, 6, leading-zero count of the accepted operand, range 0..32.
REQ-009 SHALL have port isZero, output, 1, high when the accepted operand was all zeros.

Function
REQ-010 SHALL implement two states: IDLE and SCAN.
REQ-011 IDLE with start=1 at edge E0 SHALL:
- latch a into an internal shift register;
- clear the internal accumulator and nibble index;
- enter SCAN.
REQ-012 Each SCAN edge SHALL examine the top nibble of the shift register (MSB nibble first) and act as follows:
- nibble zero: add 4 to the accumulator and shift left by 4;
- nibble nonzero: add that nibble's leading zeros (0..3) and set an internal found flag.
REQ-013 Once found is set, later nibbles SHALL NOT change the accumulator.
REQ-014 The edge that processes the final nibble SHALL:
- load count from the accumulator;
- set isZero = (accumulated count == 32);
- pulse done high for the following cycle;
- return to IDLE.
REQ-015 count and isZero SHALL change only at that completing edge, and SHALL hold their values until the next completion.
REQ-016 start asserted during SCAN SHALL be ignored, with no queuing and no restart.
REQ-017 start asserted in the cycle where done is high (state IDLE) SHALL be accepted normally, giving back-to-back operation.
REQ-018 busy SHALL be high exactly from E0 up to, and not including, the state after the completing edge.
REQ-019 The accumulator SHALL be 6 bits wide and SHALL never exceed 32, so no wrap-around is possible.

Reset
REQ-020 reset_n low SHALL immediately force all of the following, regardless of clock:
- state = IDLE;
- busy = 0, done = 0;
- count = 0, isZero = 0;
- accumulator, shift register, nibble index and found flag cleared.
REQ-021 A reset asserted mid-SCAN SHALL abort the operation with no done pulse.
REQ-022 After reset_n deasserts, the first start SHALL be accepted normally.

Configuration
REQ-023 Macro CLZ_EARLY_EXIT_EN SHALL control termination of the scan.
REQ-024 With CLZ_EARLY_EXIT_EN defined:
- SCAN SHALL complete on the edge that processes the first nonzero nibble, or after nibble 7 if the operand is all zero;
- done SHALL rise at edge E(k+1) for first-nonzero nibble index k (0 = bits 31:28).
REQ-025 With CLZ_EARLY_EXIT_EN undefined:
- SCAN SHALL always process all 8 nibbles;
- done SHALL always rise at E8, giving constant latency;
- results SHALL be identical to the defined build.

Verification
REQ-026 a=0x00000000, start at E0 -> done at E8 (both builds), count=32, isZero=1.
REQ-027 a=0x80000000 -> count=0, isZero=0; done at E1 with the macro defined, at E8 without.
REQ-028 a=0x00010000 -> count=15; done at E4 with the macro defined, at E8 without. Follow with a=0x00000001 started in the done cycle -> count=31, done at the back-to-back expected edge.
REQ-029 a=0x0F000000 at E0, then start with a=0 at E2 while busy -> second start ignored; single done; count=4.
REQ-030 reset_n pulsed low mid-SCAN after a prior result count=15 -> busy, done, count and isZero all 0 immediately; no done pulse follows; next start with a=0x00000100 -> count=23.
